// File: rtl/echo_ranger_if.sv
// Sensor/display-side signals of the ultrasonic ranger: echo in, trigger out,
// distance result to the seven-segment driver.
interface echo_ranger_if;
    logic        echo;
    logic        trig;
    logic [13:0] dis_data;
    logic        data_valid;
    logic        err;

    modport master (
        input  echo,
        output trig,
        output dis_data,
        output data_valid,
        output err
    );

    modport slave (
        output echo,
        input  trig,
        input  dis_data,
        input  data_valid,
        input  err
    );
endinterface

// File: rtl/echo_ranger.sv
// Ultrasonic ranger: periodic trigger, echo pulse timing, and divider-free
// conversion of echo width to millimetres (one mm per CYC_PER_MM cycles).
module echo_ranger #(
    parameter int TRIG_CYC     = 1000,
    parameter int PERIOD_CYC   = 6_000_000,
    parameter int WAIT_CYC     = 200_000,
    parameter int ECHO_MAX_CYC = 3_800_000,
    parameter int CYC_PER_MM   = 583,
    parameter int MAX_MM       = 9999
) (
    input  logic         clk,
    input  logic         rst_n,
    echo_ranger_if.master rng
);
    localparam int PCW = $clog2(PERIOD_CYC);
    localparam int WCW = $clog2(WAIT_CYC + 1);
    localparam int HCW = $clog2(ECHO_MAX_CYC + 1);
    localparam int SCW = $clog2(CYC_PER_MM + 1);

    localparam logic [PCW-1:0] P_LAST = PCW'(PERIOD_CYC - 1);
    localparam logic [PCW-1:0] T_LAST = PCW'(TRIG_CYC - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(WAIT_CYC - 1);
    localparam logic [HCW-1:0] E_LAST = HCW'(ECHO_MAX_CYC - 1);
    localparam logic [SCW-1:0] C_LAST = SCW'(CYC_PER_MM - 1);
    localparam logic [13:0]    MAX_V  = 14'(MAX_MM);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_ECHO = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] HOLDOFF   = 3'd5;

    logic [2:0]     state;
    logic [2:0]     sync;
    logic [PCW-1:0] pcnt;
    logic [WCW-1:0] wcnt;
    logic [HCW-1:0] hcnt;
    logic [SCW-1:0] sub;
    logic [13:0]    mm_cnt;
    logic           trig_q, dv_q, err_q;
    logic [13:0]    dis_q;
    logic           echo_rise, echo_fall, wrap;

    // sync[1] is the synchronized echo; sync[2] lags it by one so both edges
    // appear with equal latency and sync[2] is high for exactly the echo width.
    assign echo_rise = sync[1] & ~sync[2];
    assign echo_fall = ~sync[1] & sync[2];
    assign wrap      = (pcnt == P_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sync   <= '0;
            pcnt   <= '0;
            wcnt   <= '0;
            hcnt   <= '0;
            sub    <= '0;
            mm_cnt <= '0;
            trig_q <= 1'b0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
            dis_q  <= '0;
        end else begin
            sync <= {sync[1:0], rng.echo};
            dv_q <= 1'b0;
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            if (state == IDLE || wrap) begin
                state  <= TRIG;
                trig_q <= 1'b1;
                pcnt   <= '0;
            end else begin
                case (state)
                    TRIG: if (pcnt == T_LAST) begin
                        trig_q <= 1'b0;
                        wcnt   <= '0;
                        state  <= WAIT_ECHO;
                    end
                    WAIT_ECHO: if (echo_rise) begin
                        sub    <= '0;
                        mm_cnt <= '0;
                        hcnt   <= '0;
                        state  <= MEASURE;
                    end else if (wcnt == W_LAST) begin
                        err_q <= 1'b1;
                        state <= HOLDOFF;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                    MEASURE: if (sync[2]) begin
                        hcnt <= hcnt + 1'b1;
                        if (hcnt == E_LAST) begin
                            dis_q <= MAX_V;
                            dv_q  <= 1'b1;
                            err_q <= 1'b1;
                            state <= HOLDOFF;
                        end else begin
                            if (sub == C_LAST) begin
                                sub <= '0;
                                if (mm_cnt != MAX_V) mm_cnt <= mm_cnt + 14'd1;
                            end else begin
                                sub <= sub + 1'b1;
                            end
                            if (echo_fall) state <= DONE;
                        end
                    end
                    DONE: begin
                        dis_q <= mm_cnt;
                        dv_q  <= 1'b1;
                        err_q <= 1'b0;
                        state <= HOLDOFF;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rng.trig       = trig_q;
    assign rng.dis_data   = dis_q;
    assign rng.data_valid = dv_q;
    assign rng.err        = err_q;
endmodule

// File: doc/echo_ranger.md
Name: echo_ranger

Overview:
- Drives the ultrasonic ranging sensor: issues periodic trigger pulses, times the echo pulse width and converts it to distance in millimetres.
- Output dis_data[13:0] feeds the 4-digit seven-segment display driver directly (range 0..9999 mm).
- Conversion uses counting only, no divider: one mm per CYC_PER_MM clock cycles of echo-high time (round trip at 343 m/s, 100 MHz clk).

Parameters:
- TRIG_CYC, 1000, trigger high width in clk cycles (10 us).
- PERIOD_CYC, 6_000_000, trigger-start to trigger-start interval (60 ms).
- WAIT_CYC, 200_000, max cycles from trigger end to echo rising edge (2 ms).
- ECHO_MAX_CYC, 3_800_000, max echo-high cycles before overrun (38 ms).
- CYC_PER_MM, 583, echo-high cycles per millimetre.
- MAX_MM, 9999, saturation value of dis_data.

Ports:
- clk, input, 1, system clock, 100 MHz.
- rst_n, input, 1, synchronous active-low reset.
- echo, input, 1, sensor echo, asynchronous to clk.
- trig, output, 1, sensor trigger, registered.
- dis_data, output, 14, last distance in mm, registered, to the display driver.
- data_valid, output, 1, one-cycle pulse when dis_data is updated.
- err, output, 1, level; 1 = last measurement timed out or overran.

Behaviour:
- Reset: one clock and reset. rst_n is synchronous active-low and sampled on the clk rising edge. While rst_n = 0:
  - trig = 0, dis_data = 0, data_valid = 0, err = 0.
  - FSM = IDLE; all counters = 0; synchronizer flops = 0.
- Reset mid-operation aborts any measurement with no output update.
- echo is passed through a 2-flop synchronizer. Edges are detected against a third flop. Both edges share the same latency, so measured width equals the echo width.
- Period counter runs 0..PERIOD_CYC-1 and wraps. Its wrap, or leaving reset, forces the FSM to TRIG.
- Requirement: TRIG_CYC + WAIT_CYC + ECHO_MAX_CYC + 2 < PERIOD_CYC.
- FSM states:
  - IDLE: left on the first clk after rst_n = 1, into TRIG.
  - TRIG: trig = 1 for exactly TRIG_CYC cycles, then WAIT_ECHO. Echo activity is ignored.
    - trig first rises on the first clk edge with rst_n = 1.
  - WAIT_ECHO: on a synchronized echo rising edge, go to MEASURE.
    - The mm sub-counter starts at 0 and mm_cnt starts at 0.
    - After WAIT_CYC cycles with no rising edge: set err = 1, leave dis_data unchanged, no data_valid, go to HOLDOFF.
    - An echo already high on entry gives no edge, so it times out.
  - MEASURE: each cycle the synchronized echo is 1, the sub-counter increments.
    - When the sub-counter reaches CYC_PER_MM-1 it wraps to 0 and mm_cnt increments, saturating at MAX_MM.
    - On a falling edge: next cycle, dis_data = mm_cnt, data_valid = 1 for one cycle, err = 0, go to HOLDOFF.
    - Result: dis_data = min(floor(N / CYC_PER_MM), MAX_MM), where N is the echo-high cycle count.
    - Overrun, when echo-high cycles reach ECHO_MAX_CYC: dis_data = MAX_MM, data_valid = 1, err = 1, go to HOLDOFF.
  - HOLDOFF: echo ignored until the period counter wraps, then TRIG.
- dis_data holds its value between updates; the display driver samples it freely.
- The period counter is never reset by echo events. Trigger period is exactly PERIOD_CYC.

Test Plan:
- Bench overrides for all scenarios: TRIG_CYC=4, PERIOD_CYC=2000, WAIT_CYC=100, ECHO_MAX_CYC=1500, CYC_PER_MM=10, MAX_MM=9999.
- Reset and trigger cadence: hold rst_n=0 for 5 cycles, then release.
  - During reset, all outputs are 0.
  - trig is high for 4 cycles starting at the first edge after release.
  - Subsequent trig rising edges are exactly 2000 cycles apart.
- Normal measurement: echo rises 20 cycles after trig falls and stays high 123 cycles.
  - dis_data = 12, with a single data_valid pulse and err = 0.
  - The pulse occurs a fixed number of cycles after the echo falls (synchronizer latency + 1).
- Quantization boundary:
  - Echo width 9 gives dis_data = 0 with data_valid.
  - Echo width 10 gives dis_data = 1.
  - Echo width 19 gives dis_data = 1.
- No echo: echo stays 0 after a valid measurement of 12.
  - 100 cycles after trig falls, err = 1.
  - dis_data stays 12 and there is no data_valid.
  - The next good echo of width 50 gives dis_data = 5 and err = 0.
- Overrun and stuck echo:
  - Echo high for 1600 cycles: at 1500 cycles, dis_data = 9999, err = 1, data_valid pulses.
  - Echo then left high into the next period: no rising edge, so a WAIT timeout occurs (err = 1, no data_valid).
  - Echo pulses during TRIG or HOLDOFF do not change any output.
- Reset mid-measure: assert rst_n=0 for 1 cycle 50 cycles into the echo-high time.
  - Outputs go to 0 with no data_valid pulse.
  - Next cycle, trig restarts.
  - A following 70-cycle echo gives dis_data = 7.
